lsb_mem_ctrl: RTL and testbench

- Memory-side responder for the load/store buffer.
- Accepts one load or store request at a time from the LSB. Performs it as byte-serial accesses on the 8-bit RAM/IO port, little-endian.
- Returns one response per request: extended load data, or a store acknowledge.
- Sits between lsb and the top-level RAM/IO bus. Stalls IO-region stores while the UART buffer is full.

---
 rtl/lsb_mem_ctrl_pkg.sv | 28 ++
 rtl/lsb_mem_ctrl_if.sv | 30 +++
 rtl/lsb_load_ext.sv | 21 ++
 rtl/lsb_mem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lsb_mem_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsb_mem_ctrl_pkg.sv
// Shared encodings for the LSB memory-side responder: access sizes, IO region select, FSM states.
package lsb_mem_ctrl_pkg;

  localparam int ROB_WIDTH_BIT = 4;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IO_WAIT = 2'd1,
    ST_LOAD    = 2'd2,
    ST_STORE   = 2'd3
  } state_e;

  // Reserved size code 3 is handled as a word access.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: byte_count = 3'd1;
      MEM_SIZE_H: byte_count = 3'd2;
      default:    byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsb_mem_ctrl_if.sv
// Request/response handshake between the load/store buffer (master) and the memory controller (slave).
interface lsb_mem_ctrl_if
  import lsb_mem_ctrl_pkg::*;
#(
  parameter int ROB_W = ROB_WIDTH_BIT
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [ROB_W-1:0] req_rob;
  logic             resp_valid;
  logic [31:0]      resp_data;
  logic [ROB_W-1:0] resp_rob;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rob,
    input  req_ready, resp_valid, resp_data, resp_rob
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rob,
    output req_ready, resp_valid, resp_data, resp_rob
  );

endinterface

// File: rtl/lsb_load_ext.sv
// Sign/zero extension of assembled load data; shared with any future direct-IO load path.
module lsb_load_ext
  import lsb_mem_ctrl_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] ext_o
);

  // Extend from bit 7 or bit 15 depending on access size.
  always_comb begin
    ext_o = raw_i;
    case (size_i)
      MEM_SIZE_B: ext_o = {{24{signed_i & raw_i[7]}}, raw_i[7:0]};
      MEM_SIZE_H: ext_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      default:    ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/lsb_mem_ctrl.sv
// Memory-side responder for the LSB: performs one load/store at a time as little-endian
// byte-serial accesses on the 8-bit RAM/IO port and returns one response per request.
module lsb_mem_ctrl
  import lsb_mem_ctrl_pkg::*;
#(
  parameter int         ROB_W  = ROB_WIDTH_BIT,
  parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  lsb_mem_ctrl_if.slave        lsb,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [31:0]          mem_a,
  output logic                 mem_wr,
  input  logic                 io_buffer_full
);

  state_e           state_q;
  logic [2:0]       cnt_q;
  logic [31:0]      addr_q, wdata_q, data_q;
  logic [1:0]       size_q;
  logic             signed_q;
  logic [ROB_W-1:0] rob_q;
  logic             wr_q, resp_valid_q;
  logic [31:0]      resp_data_q, mem_a_q;
  logic [ROB_W-1:0] resp_rob_q;
  logic [7:0]       mem_dout_q;
  logic             paused_q;
  logic [7:0]       din_q;

  logic [2:0]  n_s;
  logic        accept_s;
  logic [7:0]  din_s, wbyte_s;
  logic [31:0] raw_s, ext_s, next_a_s;

  assign n_s      = byte_count(size_q);
  assign accept_s = lsb.req_valid && lsb.req_ready;
  assign next_a_s = addr_q + {29'd0, cnt_q};
  // The RAM keeps reading the held address during a pause, so the byte that was valid
  // when the pause began is snapshotted and consumed on the first resumed edge.
  assign din_s    = paused_q ? din_q : mem_din;

  // Store byte for the next write slot.
  always_comb begin
    wbyte_s = wdata_q[7:0];
    case (cnt_q[1:0])
      2'd0:    wbyte_s = wdata_q[7:0];
      2'd1:    wbyte_s = wdata_q[15:8];
      2'd2:    wbyte_s = wdata_q[23:16];
      default: wbyte_s = wdata_q[31:24];
    endcase
  end

  // Load data with this cycle's incoming byte merged into its lane.
  always_comb begin
    raw_s = data_q;
    case (cnt_q)
      3'd2:    raw_s[7:0]   = din_s;
      3'd3:    raw_s[15:8]  = din_s;
      3'd4:    raw_s[23:16] = din_s;
      3'd5:    raw_s[31:24] = din_s;
      default: raw_s = data_q;
    endcase
  end

  lsb_load_ext u_ext (
    .raw_i    (raw_s),
    .size_i   (size_q),
    .signed_i (signed_q),
    .ext_o    (ext_s)
  );

  // Controller FSM with registered bus and response outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      data_q       <= 32'd0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      rob_q        <= '0;
      wr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_rob_q   <= '0;
      mem_a_q      <= 32'd0;
      mem_dout_q   <= 8'd0;
      paused_q     <= 1'b0;
      din_q        <= 8'd0;
    end else if (!rdy_in) begin
      if (!paused_q) begin
        din_q    <= mem_din;
        paused_q <= 1'b1;
      end
    end else begin
      paused_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          wr_q <= 1'b0;
          if (accept_s) begin
            addr_q   <= lsb.req_addr;
            wdata_q  <= lsb.req_wdata;
            size_q   <= lsb.req_size;
            signed_q <= lsb.req_signed;
            rob_q    <= lsb.req_rob;
            data_q   <= 32'd0;
            mem_a_q  <= lsb.req_addr;
            cnt_q    <= 3'd1;
            if (lsb.req_we && (lsb.req_addr[17:16] == IO_SEL) && io_buffer_full) begin
              state_q <= ST_IO_WAIT;
            end else if (lsb.req_we) begin
              state_q    <= ST_STORE;
              wr_q       <= 1'b1;
              mem_dout_q <= lsb.req_wdata[7:0];
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_IO_WAIT: begin
          if (!io_buffer_full) begin
            state_q    <= ST_STORE;
            wr_q       <= 1'b1;
            mem_a_q    <= addr_q;
            mem_dout_q <= wdata_q[7:0];
            cnt_q      <= 3'd1;
          end
        end
        ST_STORE: begin
          if (cnt_q == n_s) begin
            state_q      <= ST_IDLE;
            wr_q         <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= 32'd0;
            resp_rob_q   <= rob_q;
          end else begin
            mem_a_q    <= next_a_s;
            mem_dout_q <= wbyte_s;
            cnt_q      <= cnt_q + 3'd1;
          end
        end
        ST_LOAD: begin
          if (flush_in) begin
            state_q <= ST_IDLE;
          end else begin
            data_q <= raw_s;
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q < n_s) begin
              mem_a_q <= next_a_s;
            end
            if (cnt_q == n_s + 3'd1) begin
              state_q      <= ST_IDLE;
              resp_valid_q <= 1'b1;
              resp_data_q  <= ext_s;
              resp_rob_q   <= rob_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign lsb.req_ready  = (state_q == ST_IDLE) && rdy_in && !flush_in;
  assign lsb.resp_valid = resp_valid_q && rdy_in;
  assign lsb.resp_data  = resp_data_q;
  assign lsb.resp_rob   = resp_rob_q;
  assign mem_wr         = wr_q && rdy_in;
  assign mem_a          = mem_a_q;
  assign mem_dout       = mem_dout_q;

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Directed bench for lsb_mem_ctrl: byte-wide RAM model with one-cycle read latency plus response/write monitors.
module tb_lsb_mem_ctrl;
  import lsb_mem_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, flush_in, io_buffer_full, mem_wr;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;

  lsb_mem_ctrl_if #(.ROB_W(ROB_WIDTH_BIT)) lsb_bus ();

  lsb_mem_ctrl #(.ROB_W(ROB_WIDTH_BIT), .IO_SEL(2'b11)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .flush_in       (flush_in),
    .lsb            (lsb_bus),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0]  ram [0:262143];
  int          cyc = 0;
  int          resp_n = 0, wr_n = 0, resp_cyc = 0, wr_cyc = 0;
  logic [31:0] resp_d_seen, wr_a_seen;
  logic [ROB_WIDTH_BIT-1:0] resp_rob_seen;
  logic [7:0]  wr_d_seen;
  int          err_cnt = 0, chk_cnt = 0;
  int          e0 = 0;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  always @(negedge clk_in) begin
    if (lsb_bus.resp_valid === 1'b1) begin
      resp_n        <= resp_n + 1;
      resp_cyc      <= cyc;
      resp_d_seen   <= lsb_bus.resp_data;
      resp_rob_seen <= lsb_bus.resp_rob;
    end
    if (mem_wr === 1'b1) begin
      wr_n      <= wr_n + 1;
      wr_cyc    <= cyc;
      wr_a_seen <= mem_a;
      wr_d_seen <= mem_dout;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [ROB_WIDTH_BIT-1:0] rob);
    int n;
    lsb_bus.req_valid  = 1'b1;
    lsb_bus.req_we     = we;
    lsb_bus.req_size   = size;
    lsb_bus.req_signed = sgn;
    lsb_bus.req_addr   = addr;
    lsb_bus.req_wdata  = wdata;
    lsb_bus.req_rob    = rob;
    #1;
    n = 0;
    while (lsb_bus.req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (lsb_bus.req_ready !== 1'b1) check_eq("req_ready_timeout", 32'(lsb_bus.req_ready), 32'd1);
    tick();
    e0 = cyc;
    lsb_bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int start, input string tag);
    int n;
    n = 0;
    while (resp_n == start && n < 40) begin
      tick();
      n++;
    end
    if (resp_n == start) check_eq({tag, "_timeout"}, 32'(resp_n), 32'(start + 1));
  endtask

  function automatic logic [31:0] rel_cyc(input int c);
    return 32'(c - e0 + 1);
  endfunction

  initial begin
    int s, w;
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
    lsb_bus.req_valid = 1'b0; lsb_bus.req_we = 1'b0; lsb_bus.req_size = 2'd0;
    lsb_bus.req_signed = 1'b0; lsb_bus.req_addr = 32'd0; lsb_bus.req_wdata = 32'd0;
    lsb_bus.req_rob = '0;
    #12;
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("rst_resp_valid", 32'(lsb_bus.resp_valid), 32'd0);
    check_eq("rst_resp_data", lsb_bus.resp_data, 32'd0);
    check_eq("rst_resp_rob", 32'(lsb_bus.resp_rob), 32'd0);
    check_eq("rst_req_ready", 32'(lsb_bus.req_ready), 32'd1);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();

    // Word store then word load at 0x100.
    s = resp_n; w = wr_n;
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 4'd5);
    wait_resp(s, "st_w");
    check_eq("st_w_cycle", rel_cyc(resp_cyc), 32'd5);
    check_eq("st_w_data", resp_d_seen, 32'd0);
    check_eq("st_w_rob", 32'(resp_rob_seen), 32'd5);
    check_eq("st_w_writes", 32'(wr_n - w), 32'd4);
    check_eq("st_w_ram100", 32'(ram[18'h100]), 32'h0000_00EF);
    check_eq("st_w_ram_all", {ram[18'h103], ram[18'h102], ram[18'h101], ram[18'h100]}, 32'hDEADBEEF);

    s = resp_n;
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'd9);
    wait_resp(s, "ld_w");
    check_eq("ld_w_cycle", rel_cyc(resp_cyc), 32'd6);
    check_eq("ld_w_data", resp_d_seen, 32'hDEADBEEF);
    check_eq("ld_w_rob", 32'(resp_rob_seen), 32'd9);

    // Build RAM[0x1FF..0x202] = 12 80 7F 00 through the controller.
    s = resp_n;
    issue(1'b1, 2'd1, 1'b0, 32'h200, 32'hAAAA7F80, 4'd1);
    wait_resp(s, "st_h");
    check_eq("st_h_cycle", rel_cyc(resp_cyc), 32'd3);
    s = resp_n;
    issue(1'b1, 2'd0, 1'b0, 32'h1FF, 32'h55555512, 4'd1);
    wait_resp(s, "st_b");
    check_eq("st_b_cycle", rel_cyc(resp_cyc), 32'd2);
    s = resp_n;
    issue(1'b1, 2'd0, 1'b0, 32'h202, 32'h00000000, 4'd1);
    wait_resp(s, "st_b2");

    s = resp_n;
    issue(1'b0, 2'd0, 1'b1, 32'h200, 32'h0, 4'd2);
    wait_resp(s, "ld_sb");
    check_eq("ld_sb_data", resp_d_seen, 32'hFFFFFF80);
    check_eq("ld_sb_cycle", rel_cyc(resp_cyc), 32'd3);
    s = resp_n;
    issue(1'b0, 2'd0, 1'b0, 32'h200, 32'h0, 4'd3);
    wait_resp(s, "ld_ub");
    check_eq("ld_ub_data", resp_d_seen, 32'h00000080);
    s = resp_n;
    issue(1'b0, 2'd1, 1'b1, 32'h200, 32'h0, 4'd4);
    wait_resp(s, "ld_sh");
    check_eq("ld_sh_data", resp_d_seen, 32'h00007F80);
    check_eq("ld_sh_cycle", rel_cyc(resp_cyc), 32'd4);
    s = resp_n;
    issue(1'b0, 2'd1, 1'b1, 32'h1FF, 32'h0, 4'd6);
    wait_resp(s, "ld_sh_neg");
    check_eq("ld_sh_neg_data", resp_d_seen, 32'hFFFF8012);
    s = resp_n;
    issue(1'b0, 2'd1, 1'b0, 32'h1FF, 32'h0, 4'd7);
    wait_resp(s, "ld_uh");
    check_eq("ld_uh_data", resp_d_seen, 32'h00008012);
    s = resp_n;
    issue(1'b0, 2'd3, 1'b1, 32'h1FF, 32'h0, 4'd8);
    wait_resp(s, "ld_w3");
    check_eq("ld_w3_data", resp_d_seen, 32'h007F8012);
    check_eq("ld_w3_cycle", rel_cyc(resp_cyc), 32'd6);

    // IO store stalled by a full UART buffer; a flush during the wait is ignored.
    io_buffer_full = 1'b1;
    s = resp_n; w = wr_n;
    issue(1'b1, 2'd0, 1'b0, 32'h30000, 32'h00000041, 4'd10);
    tick(); tick();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    tick(); tick();
    check_eq("io_no_write_full", 32'(wr_n - w), 32'd0);
    io_buffer_full = 1'b0;
    wait_resp(s, "io_st");
    repeat (4) tick();
    check_eq("io_writes", 32'(wr_n - w), 32'd1);
    check_eq("io_wr_cycle", rel_cyc(wr_cyc), 32'd7);
    check_eq("io_wr_addr", wr_a_seen, 32'h30000);
    check_eq("io_wr_data", 32'(wr_d_seen), 32'h41);
    check_eq("io_resp_cycle", rel_cyc(resp_cyc), 32'd8);
    check_eq("io_resp_count", 32'(resp_n - s), 32'd1);
    check_eq("io_resp_rob", 32'(resp_rob_seen), 32'd10);

    // Flush in cycle 2 of a word load.
    s = resp_n;
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'd3);
    tick();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    #1;
    check_eq("flush_req_ready", 32'(lsb_bus.req_ready), 32'd1);
    repeat (8) tick();
    check_eq("flush_no_resp", 32'(resp_n - s), 32'd0);
    s = resp_n;
    issue(1'b0, 2'd0, 1'b0, 32'h200, 32'h0, 4'd4);
    wait_resp(s, "after_flush");
    check_eq("after_flush_data", resp_d_seen, 32'h00000080);
    check_eq("after_flush_rob", 32'(resp_rob_seen), 32'd4);

    // Three-cycle pause in the middle of a word load.
    s = resp_n;
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'd2);
    tick();
    rdy_in = 1'b0;
    repeat (3) tick();
    rdy_in = 1'b1;
    wait_resp(s, "pause");
    check_eq("pause_data", resp_d_seen, 32'hDEADBEEF);
    check_eq("pause_cycle", rel_cyc(resp_cyc), 32'd9);
    check_eq("pause_rob", 32'(resp_rob_seen), 32'd2);

    // Asynchronous reset in the middle of a word store.
    s = resp_n; w = wr_n;
    issue(1'b1, 2'd2, 1'b0, 32'h300, 32'h11223344, 4'd7);
    tick();
    #1;
    rst_n_in = 1'b0;
    #1;
    check_eq("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("mid_rst_mem_a", mem_a, 32'd0);
    check_eq("mid_rst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("mid_rst_resp_valid", 32'(lsb_bus.resp_valid), 32'd0);
    check_eq("mid_rst_resp_data", lsb_bus.resp_data, 32'd0);
    check_eq("mid_rst_resp_rob", 32'(lsb_bus.resp_rob), 32'd0);
    rst_n_in = 1'b1;
    repeat (10) tick();
    check_eq("mid_rst_no_resp", 32'(resp_n - s), 32'd0);
    check_eq("mid_rst_writes", 32'(wr_n - w), 32'd1);
    check_eq("mid_rst_ram300", 32'(ram[18'h300]), 32'h44);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
